// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared constants, FSM encoding and double-dabble step for the stopwatch display.
package stopwatch_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int CONV_CYCLES = 6;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  // One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift {bcd, bin} left by one.
  // Returns {bcd_next[7:0], bin_next[5:0]}.
  function automatic logic [13:0] dd_step(input logic [7:0] bcd, input logic [5:0] bin);
    logic [7:0] a;
    a[3:0] = bcd[3:0] >= 4'd5 ? bcd[3:0] + 4'd3 : bcd[3:0];
    a[7:4] = bcd[7:4] >= 4'd5 ? bcd[7:4] + 4'd3 : bcd[7:4];
    return {a, bin} << 1;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low 7-segment pattern (seg[0]=a .. seg[6]=g); codes A-F blank.
//   bcd : 4-bit digit in
//   seg : 7-bit active-low segment pattern out
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display: converts binary MM/SS to BCD sequentially and scans a 4-digit common-anode display as MM.SS.
//   clk, reset    : 100 MHz clock, asynchronous active-high reset
//   seconds       : binary seconds 0-63
//   minutes       : binary minutes 0-63
//   an            : active-low digit enables, an[0] = rightmost
//   seg, dp       : active-low segments (seg[0]=a) and decimal point
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            seconds,
  input  logic [5:0]            minutes,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  state_t state, state_next;
  logic [2:0] step;
  logic [5:0] sec_sh, min_sh;
  logic [7:0] sec_bcd, min_bcd;
  logic [13:0] sec_nx, min_nx;
  logic [11:0] cap_cv, last_cv;
  logic [15:0] disp_bcd;
  logic [CW-1:0] refresh_cnt;
  logic [$clog2(NUM_DIGITS)-1:0] idx;
  logic changed, terminal;
  logic [3:0] nibble;
  logic [6:0] seg_dec;
  assign changed = {minutes, seconds} != last_cv;
  assign terminal = refresh_cnt == CW'(REFRESH_DIV - 1);
  assign sec_nx = dd_step(sec_bcd, sec_sh);
  assign min_nx = dd_step(min_bcd, min_sh);
  assign nibble = disp_bcd[{idx, 2'b00} +: 4];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    if (state == IDLE) state_next = changed ? CONV : IDLE;
    else if (state == CONV) state_next = step == 3'(CONV_CYCLES - 1) ? LOAD : CONV;
    else state_next = IDLE;
  end
  // Conversion datapath; cap_cv remembers the value being converted so last_cv matches what was displayed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step <= '0;
      sec_sh <= '0;
      min_sh <= '0;
      sec_bcd <= '0;
      min_bcd <= '0;
      cap_cv <= '0;
      last_cv <= '0;
      disp_bcd <= '0;
    end else if (state == IDLE && changed) begin
      sec_sh <= seconds;
      min_sh <= minutes;
      sec_bcd <= '0;
      min_bcd <= '0;
      cap_cv <= {minutes, seconds};
      step <= '0;
    end else if (state == CONV) begin
      {sec_bcd, sec_sh} <= sec_nx;
      {min_bcd, min_sh} <= min_nx;
      step <= step + 3'd1;
    end else if (state == LOAD) begin
      disp_bcd <= {min_bcd, sec_bcd};
      last_cv <= cap_cv;
    end
  end
  // Scan and output registers; outputs reflect the index before it advances, so there is no blank slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx <= '0;
      an <= '1;
      seg <= SEG_BLANK;
      dp <= 1'b1;
    end else begin
      refresh_cnt <= terminal ? '0 : refresh_cnt + 1'b1;
      if (terminal) idx <= idx + 1'b1;
      an <= ~(NUM_DIGITS'(1) << idx);
      seg <= seg_dec;
      dp <= idx != 2'd2;
    end
  end
  seg7_decode u_dec (
    .bcd(nibble),
    .seg(seg_dec)
  );
endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Display-side consumer of the stopwatch's binary `seconds`/`minutes` outputs. It converts each value to two BCD digits with a sequential double-dabble engine and drives a time-multiplexed 4-digit common-anode 7-segment display in MM.SS format. It sits between the stopwatch counter and the board's display pins, and runs on the same 100 MHz clock.

## Interface
- `REFRESH_DIV`, default 100_000: clocks per digit slot (1 kHz digit rate, 250 Hz frame at 100 MHz); minimum 2.
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: reset, asynchronous, active-high; clock `clk`.
- `seconds` input 6: binary seconds, 0–63 accepted.
- `minutes` input 6: binary minutes, 0–63 accepted.
- `an` output 4: digit enables, active-low; `an[0]` is the rightmost digit.
- `seg` output 7: segment cathodes, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp` output 1: decimal point, active-low.

## Operation
- Digit map: index 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens. `dp`=0 only while index 2 is shown, which gives the MM.SS separator.
- Conversion FSM states:
  - IDLE: compare `{minutes,seconds}` with `last_cv`. If they differ, load both into shift registers, clear the BCD accumulators and go to CONV.
  - CONV: exactly 6 cycles. Each cycle does add-3 on every BCD nibble ≥5, then a left shift. Both values convert in parallel.
  - LOAD: one cycle. Write all 4 nibbles into `disp_bcd` atomically, set `last_cv`, return to IDLE.
- Input changes during CONV/LOAD are ignored. Back in IDLE they are re-compared and reconverted if still different. A partial result never reaches `disp_bcd`.
- Values 60–63 convert normally (e.g. 63 → "63"). No saturation, no error flag.
- Scan: `refresh_cnt` counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Outputs are registered every cycle from the current index and `disp_bcd`:
  - `an` = one-hot-low of the index.
  - `seg` = decoded nibble for that digit.
  - Nibble codes A–F drive all segments off. They are unreachable in normal use.
- Segment patterns (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- Reset values:
  - `an`=1111, `seg`=1111111, `dp`=1.
  - FSM=IDLE, `refresh_cnt`=0, index=0, `disp_bcd`=0000, `last_cv`=0.
- First edge after reset release: `an`=1110, `seg`=1000000, `dp`=1.
- Conversion latency:
  - Change seen in IDLE at edge k.
  - `disp_bcd` updated at edge k+8 (1 load + 6 CONV + 1 LOAD).
  - Visible on the pins at edge k+9 if that digit is currently selected.
- Digit change: index advances on the edge where `refresh_cnt` = REFRESH_DIV-1. `an`/`seg`/`dp` follow one edge later. There is no blanking gap.
- Reset mid-conversion aborts to IDLE with `disp_bcd`=0. Nonzero inputs after release restart conversion immediately.
- Stopwatch rollover 59:59→00:00 is an ordinary change and gets one conversion.

## Structure
- Shared package/header `stopwatch_pkg`:
  - segment pattern constants (0–9, blank)
  - digit-count constant (4)
  - FSM state encodings (IDLE, CONV, LOAD)
- Sub-module `seg7_decode`: combinational, 4-bit BCD in, 7-bit active-low pattern out. Instantiated once, after the digit mux.
- The top level contains the conversion FSM, the scan counter and the output registers.

## Test plan
- Reset, then release with `seconds`=0, `minutes`=0 → next edge `an`=1110, `seg`=1000000. Over four slots (REFRESH_DIV=4 in sim) `an` cycles 1110, 1101, 1011, 0111, with `dp`=0 only at 1011.
- Drive `minutes`=12, `seconds`=34 → exactly 8 edges later `disp_bcd`=1,2,3,4. Per-slot `seg` reads 4=0011001, 3=0110000, 2=0100100, 1=1111001.
- Change `seconds` 34→35 during the 3rd CONV cycle → first result 12:34 is loaded, then a second conversion starts in IDLE. `disp_bcd` ends at 12:35 and no intermediate value ever appears.
- Step from 59:59 to 00:00 → display shows 5959 and then 0000. `seg` for every digit equals 1000000.
- Assert `reset` in the middle of CONV → `an`/`seg`/`dp` go to 1111/1111111/1 asynchronously. After release with inputs 07:08, the display shows 0708 after 9 edges.
- Apply `seconds`=63, `minutes`=60 → digits 6,3 and 6,0 are decoded correctly with no blank digits.
